seq_mult_hs: RTL and testbench

//   Parametrised iterative shift-add multiplier with valid/ready handshakes on

---
 rtl/seq_mult_hs_pkg.sv | 16 +
 rtl/seq_mult_hs_if.sv | 24 ++
 rtl/seq_mult_hs_step.sv | 16 +
 rtl/seq_mult_hs.sv | 97 +++++++++
 tb/tb_seq_mult_hs.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/seq_mult_hs_pkg.sv
// Shared types for the iterative shift-add multiplier: FSM state encoding and
// the counter-width helper.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Step-counter width: $clog2(width) bits are enough to count 0..width-1.
    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/seq_mult_hs_if.sv
// Operand/product handshake bundle between producer/consumer (master) and the
// multiplier (slave).
interface seq_mult_hs_if #(
    parameter int WIDTH = 32
) ();
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic                 in_signed;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_data;

    modport master (
        output in_valid, in_a, in_b, in_signed, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_a, in_b, in_signed, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/seq_mult_hs_step.sv
// One shift-add iteration: conditionally add the multiplicand into the upper
// half of P, then shift the whole register right by one.
module seq_mult_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH:0]  p_i,
    input  logic [WIDTH-1:0]  mcand_i,
    output logic [2*WIDTH:0]  p_o
);
    logic [WIDTH:0] sum;

    always_comb begin
        sum = p_i[2*WIDTH:WIDTH] + (p_i[0] ? {1'b0, mcand_i} : '0);
        p_o = {1'b0, sum, p_i[WIDTH-1:1]};
    end
endmodule

// File: rtl/seq_mult_hs.sv
// Iterative WIDTH-cycle multiplier with valid/ready on both sides. Signed
// operations are done on magnitudes and the sign is restored on the last step.
//
// state  | meaning
// S_IDLE | waiting for an operand pair, in_ready high
// S_CALC | one shift-add step per clock, WIDTH steps
// S_DONE | product presented, waiting for out_ready
module seq_mult_hs
    import seq_mult_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic          clock,
    input  logic          reset_n,
    seq_mult_hs_if.slave  bus,
    output logic          busy
);
    localparam int CNT_W = cnt_w(WIDTH);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [WIDTH-1:0]     mcand_q;
    logic [2*WIDTH:0]     p_q;
    logic [2*WIDTH:0]     p_next;
    logic                 neg_q;
    logic [2*WIDTH-1:0]   out_data_q;

    logic                 signed_act;
    logic                 last_step;
    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [2*WIDTH-1:0]   prod;

    // The most negative operand negates to itself, which is its correct magnitude.
    assign signed_act = SIGNED_EN & bus.in_signed;
    assign a_mag      = (signed_act && bus.in_a[WIDTH-1]) ? -bus.in_a : bus.in_a;
    assign b_mag      = (signed_act && bus.in_b[WIDTH-1]) ? -bus.in_b : bus.in_b;
    assign last_step  = (cnt_q == CNT_W'(WIDTH-1));
    assign prod       = p_next[2*WIDTH-1:0];

    seq_mult_step #(.WIDTH(WIDTH)) u_step (
        .p_i     (p_q),
        .mcand_i (mcand_q),
        .p_o     (p_next)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (bus.in_valid)  state_d = S_CALC;
            S_CALC:  if (last_step)     state_d = S_DONE;
            S_DONE:  if (bus.out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // in_ready is held low while reset is asserted so every output reads 0.
    always_comb begin
        bus.in_ready  = (state_q == S_IDLE) && reset_n;
        bus.out_valid = (state_q == S_DONE);
        busy          = (state_q == S_CALC) || (state_q == S_DONE);
        bus.out_data  = out_data_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            mcand_q    <= '0;
            p_q        <= '0;
            neg_q      <= 1'b0;
            out_data_q <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        mcand_q <= a_mag;
                        p_q     <= {{(WIDTH+1){1'b0}}, b_mag};
                        neg_q   <= signed_act & (bus.in_a[WIDTH-1] ^ bus.in_b[WIDTH-1]);
                        cnt_q   <= '0;
                    end
                end
                S_CALC: begin
                    p_q   <= p_next;
                    cnt_q <= cnt_q + 1'b1;
                    if (last_step) out_data_q <= neg_q ? -prod : prod;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_mult_hs.sv
// Scoreboard bench for seq_mult_hs: a 32-bit signed-capable instance and an
// 8-bit unsigned-only instance, directed vectors with hand-computed products.
module tb_seq_mult_hs;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_mult_hs_if #(.WIDTH(32)) if32 ();
    seq_mult_hs_if #(.WIDTH(8))  if8 ();
    logic busy32, busy8;

    seq_mult_hs #(.WIDTH(32), .SIGNED_EN(1'b1)) dut32 (
        .clock(clk), .reset_n(rst_n), .bus(if32.slave), .busy(busy32));
    seq_mult_hs #(.WIDTH(8), .SIGNED_EN(1'b0)) dut8 (
        .clock(clk), .reset_n(rst_n), .bus(if8.slave), .busy(busy8));

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] sb32[$];
    logic [15:0] sb8[$];

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitors: compare on every product handshake, sampled clear of the edges.
    initial forever begin
        @(negedge clk); #1;
        if (if32.out_valid && if32.out_ready) begin
            if (sb32.size() == 0) check64("sb32_unexpected", if32.out_data, 64'hDEAD_0000_0000_DEAD);
            else                  check64("sb32_result", if32.out_data, sb32.pop_front());
        end
    end

    initial forever begin
        @(negedge clk); #1;
        if (if8.out_valid && if8.out_ready) begin
            if (sb8.size() == 0) check64("sb8_unexpected", 64'(if8.out_data), 64'hDEAD);
            else                 check64("sb8_result", 64'(if8.out_data), 64'(sb8.pop_front()));
        end
    end

    task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [63:0] exp);
        int t;
        @(negedge clk);
        t = 0;
        while (!if32.in_ready && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) check64("send32_timeout", 64'(t), 64'd0);
        sb32.push_back(exp);
        if32.in_valid = 1'b1; if32.in_a = a; if32.in_b = b; if32.in_signed = s;
        @(negedge clk);
        if32.in_valid = 1'b0;
    endtask

    // Counts negedges with in_ready low after acceptance; also flags any without busy.
    task automatic drain32(output int low, output int bad);
        low = 0; bad = 0;
        while (!if32.in_ready && low < 100) begin
            if (!busy32) bad++;
            low++;
            @(negedge clk);
        end
    endtask

    task automatic wait_out32(output int n);
        n = 0;
        while (!if32.out_valid && n < 100) begin @(negedge clk); n++; end
    endtask

    task automatic op32(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [63:0] exp);
        int low, bad;
        send32(a, b, s, exp);
        drain32(low, bad);
        check64({name, "_busy_window"}, 64'(low), 64'd33);
        check64({name, "_busy_high"}, 64'(bad), 64'd0);
    endtask

    task automatic op8(input string name, input logic [7:0] a, input logic [7:0] b,
                       input logic s, input logic [15:0] exp);
        int n;
        @(negedge clk);
        sb8.push_back(exp);
        if8.in_valid = 1'b1; if8.in_a = a; if8.in_b = b; if8.in_signed = s;
        @(negedge clk);
        if8.in_valid = 1'b0;
        n = 0;
        while (!if8.out_valid && n < 100) begin @(negedge clk); n++; end
        check64({name, "_latency"}, 64'(n), 64'd8);
        @(negedge clk);
    endtask

    initial begin
        int n, low, bad;
        if32.in_valid = 1'b0; if32.in_a = '0; if32.in_b = '0; if32.in_signed = 1'b0;
        if32.out_ready = 1'b1;
        if8.in_valid = 1'b0; if8.in_a = '0; if8.in_b = '0; if8.in_signed = 1'b0;
        if8.out_ready = 1'b1;

        #2;
        check64("rst_out_valid", 64'(if32.out_valid), 64'd0);
        check64("rst_out_data", if32.out_data, 64'd0);
        check64("rst_busy", 64'(busy32), 64'd0);
        check64("rst_in_ready_held", 64'(if32.in_ready), 64'd0);
        check64("rst_out_data8", 64'(if8.out_data), 64'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        #1;
        check64("rst_in_ready", 64'(if32.in_ready), 64'd1);

        // Basic product and latency.
        send32(32'd111, 32'd111, 1'b0, 64'd12321);
        wait_out32(n);
        check64("t1_latency", 64'(n), 64'd32);

        // Back-to-back unsigned operations.
        op32("t2a", 32'd1111, 32'd1111, 1'b0, 64'd1234321);
        op32("t2b", 32'd11111, 32'd11111, 1'b0, 64'd123454321);

        // Signed/unsigned corners.
        op32("t3_neg3x5", 32'hFFFF_FFFD, 32'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1);
        op32("t3_minsq", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
        op32("t3_umaxsq", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
        op32("t3_m1xm1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'd1);
        op32("t3_zero_neg", 32'd0, 32'hFFFF_FFFB, 1'b1, 64'd0);
        op32("t3_7xm6", 32'd7, 32'hFFFF_FFFA, 1'b1, 64'hFFFF_FFFF_FFFF_FFD6);

        // Backpressure with a second operand pair waiting.
        if32.out_ready = 1'b0;
        send32(32'd10, 32'd50, 1'b0, 64'd500);
        wait_out32(n);
        check64("t4_latency", 64'(n), 64'd32);
        if32.in_valid = 1'b1; if32.in_a = 32'd10; if32.in_b = 32'd60; if32.in_signed = 1'b0;
        sb32.push_back(64'd600);
        for (int i = 0; i < 5; i++) begin
            check64("t4_hold_valid", 64'(if32.out_valid), 64'd1);
            check64("t4_hold_data", if32.out_data, 64'd500);
            check64("t4_hold_in_ready", 64'(if32.in_ready), 64'd0);
            @(negedge clk);
        end
        if32.out_ready = 1'b1;
        @(negedge clk);
        check64("t4_release_valid", 64'(if32.out_valid), 64'd0);
        check64("t4_release_in_ready", 64'(if32.in_ready), 64'd1);
        check64("t4_release_busy", 64'(busy32), 64'd0);
        check64("t4_release_data", if32.out_data, 64'd500);
        @(negedge clk);
        if32.in_valid = 1'b0;
        check64("t4_second_accept", 64'(busy32), 64'd1);
        drain32(low, bad);
        check64("t4_second_window", 64'(low), 64'd33);

        // Reset mid-calculation.
        send32(32'd10, 32'd20, 1'b0, 64'd200);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check64("t5_rst_valid", 64'(if32.out_valid), 64'd0);
        check64("t5_rst_data", if32.out_data, 64'd0);
        check64("t5_rst_busy", 64'(busy32), 64'd0);
        check64("t5_rst_in_ready", 64'(if32.in_ready), 64'd0);
        void'(sb32.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check64("t5_post_in_ready", 64'(if32.in_ready), 64'd1);
        op32("t5_after", 32'd10, 32'd70, 1'b0, 64'd700);

        // Unsigned-only 8-bit instance ignores in_signed.
        op8("t6_ffx02", 8'hFF, 8'h02, 1'b1, 16'h01FE);
        op8("t6_81x03", 8'h81, 8'h03, 1'b1, 16'h0183);
        op8("t6_ffxff", 8'hFF, 8'hFF, 1'b1, 16'hFE01);

        repeat (5) @(negedge clk);
        check64("sb32_drained", 64'(sb32.size()), 64'd0);
        check64("sb8_drained", 64'(sb8.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
